// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file slice:
//   - rf_state_e : bulk-clear engine state encoding
//   - RF_WIDTH   : default data bits per register
//   - RF_DEPTH   : default number of registers
// ---------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// ---------------------------------------------------------------------------
// regfile_rd_port
// One read port of the register file: write-to-read bypass, zero-register
// mask and an optional output register.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   raddr      : read address
//   mem_data   : current array content at raddr (pre-edge)
//   we         : write enables of all write ports
//   waddr      : packed write addresses, port j at [j*AW +: AW]
//   wdata      : packed write data, port j at [j*WIDTH +: WIDTH]
//   rdata      : read data (combinational or registered by READ_LAT)
// ---------------------------------------------------------------------------
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int AW       = 5,
    parameter int NUM_WR   = 1,
    parameter int READ_LAT = 0,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AW-1:0]           raddr,
    input  logic [WIDTH-1:0]        mem_data,
    input  logic [NUM_WR-1:0]       we,
    input  logic [NUM_WR*AW-1:0]    waddr,
    input  logic [NUM_WR*WIDTH-1:0] wdata,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] byp_s;
    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] data_r;

    // Bypass mux: later (higher-index) write ports override earlier ones.
    always_comb begin
        byp_s = mem_data;
        for (int j = 0; j < NUM_WR; j++) begin
            byp_s = (we[j] && (waddr[j*AW +: AW] == raddr)) ? wdata[j*WIDTH +: WIDTH] : byp_s;
        end
    end

    // Zero-register mask applied after bypass so entry 0 always reads 0.
    always_comb begin
        if ((ZERO_REG == 1) && (raddr == {AW{1'b0}})) begin
            data_s = {WIDTH{1'b0}};
        end else begin
            data_s = byp_s;
        end
    end

    // Output register holding the post-write value for registered reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= {WIDTH{1'b0}};
        end else begin
            data_r <= data_s;
        end
    end

    assign rdata = (READ_LAT == 1) ? data_r : data_s;

endmodule : regfile_rd_port

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with clocked writes, configurable
// read latency, write-to-read bypass, optional hard-wired zero register and
// a sequenced bulk-clear engine (one entry per cycle, DEPTH cycles busy).
// Ports:
//   RF_clk    : clock
//   RF_reset  : synchronous active-high reset (zeroes array, aborts clear)
//   RF_raddr  : read addresses, port i at [i*AW +: AW]
//   RF_rdata  : read data, port i at [i*WIDTH +: WIDTH]
//   RF_we     : write enables
//   RF_waddr  : write addresses, port j at [j*AW +: AW]
//   RF_wdata  : write data, port j at [j*WIDTH +: WIDTH]
//   RF_clear  : pulse to start a sequenced clear
//   RF_busy   : clear in progress
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int   WIDTH    = RF_WIDTH,
    parameter int   DEPTH    = RF_DEPTH,
    parameter int   NUM_RD   = 2,
    parameter int   NUM_WR   = 1,
    parameter int   READ_LAT = 0,
    parameter int   ZERO_REG = 1,
    localparam int  AW       = $clog2(DEPTH)
) (
    input  logic                    RF_clk,
    input  logic                    RF_reset,
    input  logic [NUM_RD*AW-1:0]    RF_raddr,
    output logic [NUM_RD*WIDTH-1:0] RF_rdata,
    input  logic [NUM_WR-1:0]       RF_we,
    input  logic [NUM_WR*AW-1:0]    RF_waddr,
    input  logic [NUM_WR*WIDTH-1:0] RF_wdata,
    input  logic                    RF_clear,
    output logic                    RF_busy
);

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [NUM_WR-1:0] wr_ok_s;
    rf_state_e         state_r;
    rf_state_e         state_nx_s;
    logic [AW-1:0]     ptr_r;
    logic [AW-1:0]     ptr_nx_s;
    logic              clear_en_s;
    logic              busy_r;

    // Write qualification: drop writes to entry 0 when it is hard-wired.
    always_comb begin
        wr_ok_s = {NUM_WR{1'b0}};
        for (int j = 0; j < NUM_WR; j++) begin
            if ((ZERO_REG == 1) && (RF_waddr[j*AW +: AW] == {AW{1'b0}})) begin
                wr_ok_s[j] = 1'b0;
            end else begin
                wr_ok_s[j] = RF_we[j];
            end
        end
    end

    // Storage array: clear first, then writes in ascending port order so a
    // write to the clear pointer and the highest write port both win.
    always_ff @(posedge RF_clk) begin
        if (RF_reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_r[e] <= {WIDTH{1'b0}};
            end
        end else begin
            if (clear_en_s) begin
                mem_r[ptr_r] <= {WIDTH{1'b0}};
            end
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok_s[j]) begin
                    mem_r[RF_waddr[j*AW +: AW]] <= RF_wdata[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Clear FSM state, pointer and busy flag registers.
    always_ff @(posedge RF_clk) begin
        if (RF_reset) begin
            state_r <= RF_IDLE;
            ptr_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            busy_r  <= (state_nx_s == RF_CLEAR);
        end
    end

    // Clear FSM next state: a clear request in CLEAR is ignored; the sweep
    // ends by comparing against the last index rather than on wrap.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        case (state_r)
            RF_IDLE: begin
                if (RF_clear) begin
                    state_nx_s = RF_CLEAR;
                    ptr_nx_s   = {AW{1'b0}};
                end else begin
                    state_nx_s = RF_IDLE;
                end
            end
            RF_CLEAR: begin
                if (ptr_r == PTR_LAST) begin
                    state_nx_s = RF_IDLE;
                    ptr_nx_s   = {AW{1'b0}};
                end else begin
                    ptr_nx_s   = ptr_r + AW'(1'b1);
                end
            end
            default: begin
                state_nx_s = RF_IDLE;
                ptr_nx_s   = {AW{1'b0}};
            end
        endcase
    end

    // Clear FSM outputs.
    always_comb begin
        clear_en_s = 1'b0;
        case (state_r)
            RF_IDLE:  clear_en_s = 1'b0;
            RF_CLEAR: clear_en_s = 1'b1;
            default:  clear_en_s = 1'b0;
        endcase
    end

    assign RF_busy = busy_r;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] raddr_s;
        assign raddr_s = RF_raddr[i*AW +: AW];

        regfile_rd_port #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .NUM_WR   (NUM_WR),
            .READ_LAT (READ_LAT),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk      (RF_clk),
            .reset    (RF_reset),
            .raddr    (raddr_s),
            .mem_data (mem_r[raddr_s]),
            .we       (RF_we),
            .waddr    (RF_waddr),
            .wdata    (RF_wdata),
            .rdata    (RF_rdata[i*WIDTH +: WIDTH])
        );
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench: two register files (combinational and registered
// read) driven by the same stimulus, compared every cycle against an
// array-based reference model, plus directed literal expectations.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        clr;
    logic [63:0] rdata0, rdata1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [31:0] m_mem [32];
    bit          m_busy;
    int          m_ptr;
    logic [31:0] m_lat1 [2];

    regfile_mp #(.NUM_RD(2), .NUM_WR(2), .READ_LAT(0), .ZERO_REG(1)) dut0 (
        .RF_clk(clk), .RF_reset(rst), .RF_raddr(raddr), .RF_rdata(rdata0),
        .RF_we(we), .RF_waddr(waddr), .RF_wdata(wdata), .RF_clear(clr), .RF_busy(busy0));

    regfile_mp #(.NUM_RD(2), .NUM_WR(2), .READ_LAT(1), .ZERO_REG(1)) dut1 (
        .RF_clk(clk), .RF_reset(rst), .RF_raddr(raddr), .RF_rdata(rdata1),
        .RF_we(we), .RF_waddr(waddr), .RF_wdata(wdata), .RF_clear(clr), .RF_busy(busy1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] wa(input int j);
        logic [9:0] w;
        w = waddr;
        return w[j*5 +: 5];
    endfunction

    // value a read of addr sees this cycle: zero reg, then newest write, then array
    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        logic [31:0] v;
        if (addr == 5'd0) return 32'd0;
        v = m_mem[addr];
        for (int j = 0; j < 2; j++)
            if (we[j] && wa(j) == addr) v = wdata[j*32 +: 32];
        return v;
    endfunction

    // reference model update at each clock edge
    always @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < 32; e++) m_mem[e] <= 32'd0;
            m_busy <= 1'b0;
            m_ptr <= 0;
            m_lat1[0] <= 32'd0;
            m_lat1[1] <= 32'd0;
        end else begin
            for (int p = 0; p < 2; p++) m_lat1[p] <= exp_read(raddr[p*5 +: 5]);
            if (m_busy && !((we[0] && wa(0) == 5'(m_ptr)) || (we[1] && wa(1) == 5'(m_ptr))))
                m_mem[m_ptr] <= 32'd0;
            for (int j = 0; j < 2; j++)
                if (we[j] && wa(j) != 5'd0) m_mem[wa(j)] <= wdata[j*32 +: 32];
            if (m_busy) begin
                if (m_ptr == 31) m_busy <= 1'b0;
                m_ptr <= (m_ptr + 1) % 32;
            end else if (clr) begin
                m_busy <= 1'b1;
                m_ptr <= 0;
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                check("rdata_lat0", rdata0[p*32 +: 32], exp_read(raddr[p*5 +: 5]));
                check("rdata_lat1", rdata1[p*32 +: 32], m_lat1[p]);
            end
            check("busy_lat0", {31'd0, busy0}, {31'd0, m_busy});
            check("busy_lat1", {31'd0, busy1}, {31'd0, m_busy});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        we = 2'b00; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        we = 2'b01; waddr = {5'd0, a}; wdata = {32'd0, d};
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && busy0 === 1'b1; n++) tick();
        check("wait_idle", {31'd0, busy0}, 32'd0);
    endtask

    int busycnt;

    initial begin
        rst = 1'b1; we = 2'b00; clr = 1'b0; raddr = 10'd0; waddr = 10'd0; wdata = 64'd0;
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: everything reads zero after reset
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(31 - a)};
            @(negedge clk);
            check("reset_rd0", rdata0[31:0], 32'd0);
            check("reset_rd1", rdata0[63:32], 32'd0);
            tick();
        end
        check("reset_busy", {31'd0, busy0}, 32'd0);

        // 2: simple write / zero register
        wr0(5'd5, 32'hDEADBEEF); raddr = 10'd0;
        tick();
        quiet(); raddr = {5'd0, 5'd5};
        @(negedge clk);
        check("wr_r5", rdata0[31:0], 32'hDEADBEEF);
        tick();
        wr0(5'd0, 32'h1234); raddr = 10'd0;
        @(negedge clk);
        check("wr_r0_byp", rdata0[31:0], 32'd0);
        tick();
        quiet();
        @(negedge clk);
        check("wr_r0", rdata0[31:0], 32'd0);
        tick();

        // 3: bypass, same cycle for lat0, next cycle for lat1
        wr0(5'd7, 32'hA5A5A5A5); raddr = {5'd0, 5'd7};
        @(negedge clk);
        check("bypass_lat0", rdata0[31:0], 32'hA5A5A5A5);
        tick();
        quiet();
        @(negedge clk);
        check("bypass_lat1", rdata1[31:0], 32'hA5A5A5A5);
        tick();

        // 4: two ports write the same entry, higher port wins
        we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h2, 32'h1}; raddr = {5'd3, 5'd3};
        @(negedge clk);
        check("dual_wr_byp", rdata0[63:32], 32'h2);
        tick();
        quiet();
        @(negedge clk);
        check("dual_wr", rdata0[31:0], 32'h2);
        tick();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            we = 2'($urandom_range(0, 3));
            waddr = 10'($urandom);
            wdata = {$urandom, $urandom};
            raddr = 10'($urandom);
            if ($urandom_range(0, 1) == 0) raddr[4:0] = waddr[4:0];
            if ($urandom_range(0, 3) == 0) raddr[9:5] = waddr[9:5];
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        quiet();
        wait_idle();

        // 5: fill, sequenced clear, write wins at ptr = 31
        for (int a = 1; a < 32; a++) begin
            wr0(5'(a), 32'(a));
            tick();
        end
        quiet();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        busycnt = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 31) wr0(5'd31, 32'h55);
            else we = 2'b00;
            clr = (k == 5);
            @(negedge clk);
            if (busy0 === 1'b1) busycnt++;
            tick();
        end
        quiet();
        @(negedge clk);
        check("clear_busy_end", {31'd0, busy0}, 32'd0);
        check("clear_busy_cycles", 32'(busycnt), 32'd32);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            @(negedge clk);
            check("after_clear", rdata0[31:0], (a == 31) ? 32'h55 : 32'd0);
            tick();
        end

        // 6: reset at clear cycle 10, then a fresh clear starts at ptr 0
        wr0(5'd20, 32'h99);
        tick();
        quiet();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        raddr = {5'd20, 5'd20};
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy0}, 32'd0);
        check("rst_mid_r20", rdata0[31:0], 32'd0);
        tick();
        wr0(5'd1, 32'h11);
        tick();
        wr0(5'd2, 32'h22);
        tick();
        quiet();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        raddr = {5'd2, 5'd1};
        @(negedge clk);
        check("restart_r1", rdata0[31:0], 32'd0);
        check("restart_r2", rdata0[63:32], 32'h22);
        tick();
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_mp
